seq_detect_ctrl: RTL and testbench
==================================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 8, maximum pattern length in bits.
REQ-002 SHALL have parameter CNT_W, default 8, width of match counter and match target.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port n_rst  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port cfg_load  input  1  latch configuration (honoured in IDLE only).
REQ-006 SHALL have port cfg_pattern  input  PAT_W  pattern; bit [len-1] is first serial bit, bit [0] last.
REQ-007 SHALL have port cfg_len  input  4  pattern length, legal 2..PAT_W.
REQ-008 SHALL have port cfg_target  input  CNT_W  match count that ends a run, legal 1..2^CNT_W-1.
REQ-009 SHALL have port start  input  1  begin run (IDLE or DONE).
REQ-010 SHALL have port stop  input  1  abort run (RUN or DONE).
REQ-011 SHALL have port i  input  1  serial data bit.
REQ-012 SHALL have port i_valid  input  1  i is sampled this cycle.
REQ-013 SHALL have port o  output  1  Mealy match pulse, combinational, same cycle as last pattern bit.
REQ-014 SHALL have port busy  output  1  high in RUN.
REQ-015 SHALL have port done  output  1  high in DONE.
REQ-016 SHALL have port match_count  output  CNT_W  registered matches in current/last run.
REQ-017 SHALL have port cfg_err  output  1  registered; last latched config illegal.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE.
REQ-019 cfg_load in IDLE SHALL latch pattern/len/target next edge and set cfg_err=1 if len<2, len>PAT_W or target==0, else cfg_err=0; cfg_load in RUN/DONE SHALL be ignored.
REQ-020 start in IDLE with cfg_err=0 and a config latched since reset SHALL enter RUN next edge, clearing match_count, shift history and fill count; otherwise start SHALL be ignored.
REQ-021 cfg_load and start in the same IDLE cycle: cfg_load SHALL take effect, start SHALL be ignored.
REQ-022 In RUN, each i_valid cycle SHALL shift i into a PAT_W-bit history (new bit LSB) and increment fill count, saturating at cfg_len; cycles with i_valid=0 SHALL change nothing.
REQ-023 o SHALL be 1 iff state==RUN, i_valid=1, fill count (including current bit) >= cfg_len, and the low cfg_len bits of {history[PAT_W-2:0], i} equal cfg_pattern[cfg_len-1:0].
REQ-024 Overlapping matches SHALL be detected; history SHALL NOT clear after a match.
REQ-025 Each o=1 cycle SHALL increment match_count next edge.
REQ-026 A match bringing match_count to cfg_target SHALL move RUN->DONE next edge; this SHALL take precedence over a simultaneous stop.
REQ-027 stop in RUN without target-reaching match SHALL move to IDLE next edge; match_count SHALL retain its value (including a match counted that cycle).
REQ-028 In DONE, o SHALL be 0 and inputs i/i_valid ignored; start SHALL re-enter RUN with clearing per REQ-020; stop SHALL return to IDLE; start and stop together SHALL select stop.
REQ-029 match_count SHALL never wrap; target reach terminates the run before overflow.

Reset
REQ-030 n_rst=0 at a rising edge SHALL force IDLE, o=0, busy=0, done=0, match_count=0, cfg_err=0, history and fill cleared, config marked not-latched, regardless of state.
REQ-031 Reset asserted mid-run SHALL abandon the run with no further match pulses from the following edge.

Verification
REQ-032 Reset, load pattern=4'b1101 len=4 target=3, start, feed 1,1,0,1 -> o=1 only on 4th bit, match_count=1, busy=1.
REQ-033 Continue 1,0,1 (overlap) then 1,0,1 -> o pulses on each final 1, match_count=3, done=1 next edge, busy=0, further 1101 input gives o=0.
REQ-034 Load len=1 target=2 -> cfg_err=1; start -> state stays IDLE, busy=0.
REQ-035 RUN, feed 1,1,0 with i_valid gaps between bits, then 1 -> match only when i_valid=1 on last bit; idle cycles leave history intact.
REQ-036 RUN with match_count=1, apply stop -> IDLE next edge, match_count holds 1; stop concurrent with target-reaching match -> DONE.
REQ-037 Assert n_rst=0 for one edge mid-RUN after 1,1,0 -> all outputs 0, subsequent start ignored until new cfg_load.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector with a run controller (IDLE/RUN/DONE).
// It counts overlapping matches and stops the run when the configured target is reached.
module seq_detect_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             stop,
    input  logic             i,
    input  logic             i_valid,
    output logic             o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [PAT_W-1:0] pattern_q;
    logic [3:0]       len_q;
    logic [CNT_W-1:0] target_q;
    logic             cfg_valid;
    logic [PAT_W-1:0] history;
    logic [3:0]       fill;

    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic [3:0]       fill_inc;
    logic [CNT_W-1:0] count_next;
    logic             hit;
    logic             reach;
    logic             cfg_bad;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        window = {history[PAT_W-2:0], i};
        mask   = '0;
        for (int k = 0; k < PAT_W; k++) begin
            mask[k] = (k < int'(len_q));
        end
        fill_inc   = (fill < len_q) ? fill + 4'd1 : fill;
        hit        = (state == S_RUN) && i_valid
                     && (({1'b0, fill} + 5'd1) >= {1'b0, len_q})
                     && (((window ^ pattern_q) & mask) == '0);
        count_next = match_count + 1'b1;
        reach      = hit && (count_next == target_q);
        cfg_bad    = (cfg_len < 4'd2) || (int'(cfg_len) > PAT_W) || (cfg_target == '0);
    end

    assign o    = hit;
    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            pattern_q   <= '0;
            len_q       <= '0;
            target_q    <= '0;
            cfg_valid   <= 1'b0;
            cfg_err     <= 1'b0;
            match_count <= '0;
            history     <= '0;
            fill        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_load) begin
                        pattern_q <= cfg_pattern;
                        len_q     <= cfg_len;
                        target_q  <= cfg_target;
                        cfg_valid <= 1'b1;
                        cfg_err   <= cfg_bad;
                    end else if (start && cfg_valid && !cfg_err) begin
                        state       <= S_RUN;
                        match_count <= '0;
                        history     <= '0;
                        fill        <= '0;
                    end
                end
                S_RUN: begin
                    if (i_valid) begin
                        history <= window;
                        fill    <= fill_inc;
                    end
                    if (hit) begin
                        match_count <= count_next;
                    end
                    // Reaching the target wins over a stop in the same cycle.
                    if (reach) begin
                        state <= S_DONE;
                    end else if (stop) begin
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (start) begin
                        state       <= S_RUN;
                        match_count <= '0;
                        history     <= '0;
                        fill        <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: a queue of expected o values per cycle
// plus inline checks of the registered outputs after each scenario step.
module tb_seq_detect_ctrl;

    logic       clk;
    logic       n_rst;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [7:0] cfg_target;
    logic       start;
    logic       stop;
    logic       i;
    logic       i_valid;
    logic       o;
    logic       busy;
    logic       done;
    logic [7:0] match_count;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic exp_o_q[$];

    seq_detect_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_target (cfg_target),
        .start      (start),
        .stop       (stop),
        .i          (i),
        .i_valid    (i_valid),
        .o          (o),
        .busy       (busy),
        .done       (done),
        .match_count(match_count),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // o is combinational: check it mid-cycle, against the value queued when the stimulus was driven.
    always @(negedge clk) begin
        cycle++;
        if (exp_o_q.size() > 0) begin
            logic exp_o;
            exp_o = exp_o_q.pop_front();
            checks++;
            if (o !== exp_o) begin
                errors++;
                $display("FAIL o_pulse cycle %0d: got %b want %b", cycle, o, exp_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Runs one clock cycle with the given inputs and queues the o value expected during it.
    task automatic drive(input logic ld, input logic st, input logic sp,
                         input logic b, input logic v, input logic exp_o);
        cfg_load = ld;
        start    = st;
        stop     = sp;
        i        = b;
        i_valid  = v;
        exp_o_q.push_back(exp_o);
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        i_valid  = 1'b0;
    endtask

    task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_target  = tgt;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic feed_bits(input logic [7:0] bits, input logic [7:0] exp, input int n);
        for (int k = n - 1; k >= 0; k--) begin
            drive(1'b0, 1'b0, 1'b0, bits[k], 1'b1, exp[k]);
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_rst = 1'b1;
        checks++;
        if ({busy, done, cfg_err, match_count} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", {busy, done, cfg_err, match_count}, 11'b0);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_without_cfg: busy got %b want 0", busy);
        end
    endtask

    task automatic test_basic;
        load_cfg(8'b0000_1101, 4'd4, 8'd3);
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_cfg_err: got %b want 0", cfg_err);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({busy, done, match_count} !== {1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL basic_start: got %b want %b", {busy, done, match_count}, {1'b1, 1'b0, 8'd0});
        end
        feed_bits(8'b1101, 8'b0001, 4);
        checks++;
        if ({busy, done, match_count} !== {1'b1, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL basic_first_match: got %b want %b", {busy, done, match_count}, {1'b1, 1'b0, 8'd1});
        end
    endtask

    task automatic test_overlap;
        feed_bits(8'b101, 8'b001, 3);
        checks++;
        if (match_count !== 8'd2) begin
            errors++;
            $display("FAIL overlap_count: got %0d want 2", match_count);
        end
        feed_bits(8'b101, 8'b001, 3);
        checks++;
        if ({busy, done, match_count} !== {1'b0, 1'b1, 8'd3}) begin
            errors++;
            $display("FAIL target_done: got %b want %b", {busy, done, match_count}, {1'b0, 1'b1, 8'd3});
        end
        feed_bits(8'b1101, 8'b0000, 4);
        checks++;
        if ({done, match_count} !== {1'b1, 8'd3}) begin
            errors++;
            $display("FAIL done_ignores_input: got %b want %b", {done, match_count}, {1'b1, 8'd3});
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({busy, done, match_count} !== {1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL done_restart: got %b want %b", {busy, done, match_count}, {1'b1, 1'b0, 8'd0});
        end
        // Fresh history after restart: 1,0,1 alone must not match.
        feed_bits(8'b101, 8'b000, 3);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({busy, done, match_count} !== {1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL restart_clears: got %b want %b", {busy, done, match_count}, {1'b0, 1'b0, 8'd0});
        end
    endtask

    task automatic test_cfg_err;
        logic [3:0] bad_len[3]  = '{4'd1, 4'd9, 4'd4};
        logic [7:0] bad_tgt[3]  = '{8'd2, 8'd2, 8'd0};
        for (int k = 0; k < 3; k++) begin
            load_cfg(8'b0000_1101, bad_len[k], bad_tgt[k]);
            checks++;
            if (cfg_err !== 1'b1) begin
                errors++;
                $display("FAIL cfg_err_set case %0d: got %b want 1", k, cfg_err);
            end
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_start case %0d: busy got %b want 0", k, busy);
            end
        end
    endtask

    task automatic test_gaps;
        logic [8:0] bv  = 9'b1_0_1_1_0_0_0_1_1;
        logic [8:0] vv  = 9'b1_0_1_0_0_1_0_0_1;
        logic [8:0] ev  = 9'b0_0_0_0_0_0_0_0_1;
        load_cfg(8'b0000_1101, 4'd4, 8'd5);
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL gaps_cfg_err: got %b want 0", cfg_err);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 8; k >= 0; k--) begin
            drive(1'b0, 1'b0, 1'b0, bv[k], vv[k], ev[k]);
        end
        checks++;
        if ({busy, match_count} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL gaps_match: got %b want %b", {busy, match_count}, {1'b1, 8'd1});
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({busy, done, match_count} !== {1'b0, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL stop_holds_count: got %b want %b", {busy, done, match_count}, {1'b0, 1'b0, 8'd1});
        end
    endtask

    task automatic test_stop_vs_target;
        load_cfg(8'b0000_1101, 4'd4, 8'd2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed_bits(8'b1101, 8'b0001, 4);
        feed_bits(8'b10, 8'b00, 2);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({busy, done, match_count} !== {1'b0, 1'b1, 8'd2}) begin
            errors++;
            $display("FAIL stop_vs_target: got %b want %b", {busy, done, match_count}, {1'b0, 1'b1, 8'd2});
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL done_start_stop: got %b want 00", {busy, done});
        end
        cfg_pattern = 8'b0000_1101;
        cfg_len     = 4'd4;
        cfg_target  = 8'd2;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL load_and_start: busy got %b want 0", busy);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed_bits(8'b110, 8'b000, 3);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({busy, done, match_count} !== {1'b0, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL stop_with_match: got %b want %b", {busy, done, match_count}, {1'b0, 1'b0, 8'd1});
        end
    endtask

    task automatic test_reset_mid_run;
        load_cfg(8'b0000_1101, 4'd4, 8'd3);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed_bits(8'b110, 8'b000, 3);
        n_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        checks++;
        if ({busy, done, cfg_err, match_count} !== 11'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got %b want %b", {busy, done, cfg_err, match_count}, 11'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_after_reset: busy got %b want 0", busy);
        end
        load_cfg(8'b0000_1101, 4'd4, 8'd3);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_after_reload: busy got %b want 1", busy);
        end
    endtask

    initial begin
        n_rst       = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_target  = '0;
        start       = 1'b0;
        stop        = 1'b0;
        i           = 1'b0;
        i_valid     = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_basic;
        test_overlap;
        test_cfg_err;
        test_gaps;
        test_stop_vs_target;
        test_reset_mid_run;
        @(negedge clk);
        checks++;
        if (exp_o_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_o_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
